// File: rtl/audio_delay_line_ctrl.sv
// audio_delay_line_ctrl: drives a single-port read-first BRAM as a variable-length audio delay line.
//
// Each accepted sample causes one read of the sample written d samples earlier,
// followed by a write of the new sample. The read data comes back on
// delayed_out, qualified by a one-cycle delayed_valid_out strobe.
//
// Parameters:
//   SAMPLE_WIDTH  sample and RAM data width
//   DEPTH         RAM entries (power of two)
//   RAM_LATENCY   RAM read latency, 1 (no output register) or 2 (output register)
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   sample_in/_valid_in     input sample stream; accepted when ready_out is high
//   delay_in                delay in samples, 0 selects the full DEPTH delay
//   ready_out               high only while idle
//   delayed_out/_valid_out  delayed sample and its one-cycle strobe
//   ram_*_out, ram_dout_in  RAM master port (all outputs registered)
//
// Build option: define DELAY_LINE_CLEAR_EN to zero the whole RAM after every
// reset release before the first sample is accepted.
module audio_delay_line_ctrl #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 1024,
    parameter int RAM_LATENCY  = 2,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [AW-1:0]           delay_in,
    output logic                    ready_out,
    output logic [SAMPLE_WIDTH-1:0] delayed_out,
    output logic                    delayed_valid_out,
    output logic [AW-1:0]           ram_addr_out,
    output logic [SAMPLE_WIDTH-1:0] ram_din_out,
    output logic                    ram_en_out,
    output logic                    ram_we_out,
    output logic                    ram_regce_out,
    input  logic [SAMPLE_WIDTH-1:0] ram_dout_in
);

`ifdef DELAY_LINE_CLEAR_EN
    typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_RD, ST_WR, ST_WAIT} state_t;
    localparam state_t ST_RESET    = ST_CLEAR;
    localparam logic   READY_RESET = 1'b0;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_WAIT} state_t;
    localparam state_t ST_RESET    = ST_IDLE;
    localparam logic   READY_RESET = 1'b1;
`endif

    state_t                  state_q, state_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           delay_q, delay_d;
    logic                    ready_q, ready_d;
    logic [SAMPLE_WIDTH-1:0] delayed_q, delayed_d;
    logic                    dvalid_q, dvalid_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [SAMPLE_WIDTH-1:0] din_q, din_d;
    logic                    en_q, en_d;
    logic                    we_q, we_d;
`ifdef DELAY_LINE_CLEAR_EN
    logic [AW-1:0]           clr_q, clr_d;
`endif

    // RAM-side outputs are computed for the state being entered, so they are
    // presented during that state's own cycle.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        delay_d   = delay_q;
        ready_d   = ready_q;
        delayed_d = delayed_q;
        dvalid_d  = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        en_d      = 1'b0;
        we_d      = 1'b0;
`ifdef DELAY_LINE_CLEAR_EN
        clr_d     = clr_q;
`endif
        case (state_q)
`ifdef DELAY_LINE_CLEAR_EN
            // The last sweep write overlaps the first idle cycle so that
            // ready rises DEPTH cycles after release.
            ST_CLEAR: begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = clr_q;
                din_d  = '0;
                clr_d  = clr_q + 1'b1;
                if (clr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
`endif
            ST_IDLE: begin
                if (sample_valid_in && ready_q) begin
                    state_d = ST_RD;
                    ready_d = 1'b0;
                    delay_d = delay_in;
                    din_d   = sample_in;
                    en_d    = 1'b1;
                    // d=0 reads and writes wptr in one read-first access.
                    we_d    = (delay_in == '0);
                    addr_d  = wptr_q - delay_in;
                end
            end
            ST_RD: begin
                state_d = ST_WR;
                en_d    = (delay_q != '0);
                we_d    = (delay_q != '0);
                addr_d  = wptr_q;
            end
            ST_WR: begin
                wptr_d    = wptr_q + 1'b1;
                state_d   = (RAM_LATENCY == 1) ? ST_IDLE : ST_WAIT;
                ready_d   = (RAM_LATENCY == 1);
                dvalid_d  = (RAM_LATENCY == 1);
                delayed_d = (RAM_LATENCY == 1) ? ram_dout_in : delayed_q;
            end
            ST_WAIT: begin
                state_d   = ST_IDLE;
                ready_d   = 1'b1;
                dvalid_d  = 1'b1;
                delayed_d = ram_dout_in;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_RESET;
            wptr_q    <= '0;
            delay_q   <= '0;
            ready_q   <= READY_RESET;
            delayed_q <= '0;
            dvalid_q  <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
`ifdef DELAY_LINE_CLEAR_EN
            clr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            delay_q   <= delay_d;
            ready_q   <= ready_d;
            delayed_q <= delayed_d;
            dvalid_q  <= dvalid_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            en_q      <= en_d;
            we_q      <= we_d;
`ifdef DELAY_LINE_CLEAR_EN
            clr_q     <= clr_d;
`endif
        end
    end

    assign ready_out         = ready_q;
    assign delayed_out       = delayed_q;
    assign delayed_valid_out = dvalid_q;
    assign ram_addr_out      = addr_q;
    assign ram_din_out       = din_q;
    assign ram_en_out        = en_q;
    assign ram_we_out        = we_q;
    assign ram_regce_out     = 1'b1;

endmodule
